// File: rtl/mmd_pkg.sv
// Shared FSM state type and default memory map for the MMIO bus decoder.
package mmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } mmd_state_t;

    // Default map: GPIO and UART are carved out of the data window, so they must keep lower indices.
    localparam logic [31:0] ADDR_PROGRAM_BASE  = 32'h0040_0000;
    localparam logic [31:0] ADDR_PROGRAM_LIMIT = 32'h0FFF_FFFF;
    localparam logic [31:0] ADDR_GPIO_BASE     = 32'h1001_0024;
    localparam logic [31:0] ADDR_GPIO_LIMIT    = 32'h1001_002B;
    localparam logic [31:0] ADDR_UART_BASE     = 32'h1001_002C;
    localparam logic [31:0] ADDR_UART_LIMIT    = 32'h1001_003B;
    localparam logic [31:0] ADDR_DATA_BASE     = 32'h1001_0000;
    localparam logic [31:0] ADDR_DATA_LIMIT    = 32'h7FFF_FFFF;

    localparam int MMD_MAX_SLV = 16;

endpackage

// File: rtl/mmd_region_match.sv
// Combinational window check: hit when base <= addr <= limit (unsigned, inclusive).
module mmd_region_match #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_limit,
    input  logic [AW-1:0] i_addr,
    output logic          o_hit
);

    assign o_hit = (i_addr >= i_base) && (i_addr <= i_limit);

endmodule

// File: rtl/mmio_bus_decoder.sv
// Handshaked memory-map decoder between the uP load/store port and N_SLV slaves.
// Define MMD_TIMEOUT_EN to turn a missing slave ack into a bus error after TO_CYCLES.
module mmio_bus_decoder
    import mmd_pkg::*;
#(
    parameter int                  DW        = 32,
    parameter int                  AW        = 32,
    parameter int                  N_SLV     = 4,
    parameter logic [N_SLV*AW-1:0] BASE      = {ADDR_DATA_BASE, ADDR_UART_BASE,
                                                ADDR_GPIO_BASE, ADDR_PROGRAM_BASE},
    parameter logic [N_SLV*AW-1:0] LIMIT     = {ADDR_DATA_LIMIT, ADDR_UART_LIMIT,
                                                ADDR_GPIO_LIMIT, ADDR_PROGRAM_LIMIT},
    parameter int                  TO_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_err,
    output logic [AW-1:0]       slv_addr,
    output logic [DW-1:0]       slv_wdata,
    output logic                slv_we,
    output logic [N_SLV-1:0]    slv_sel,
    input  logic [N_SLV*DW-1:0] slv_rdata,
    input  logic [N_SLV-1:0]    slv_ack
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    if (N_SLV < 1 || N_SLV > MMD_MAX_SLV || TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_badParam
        $error("mmio_bus_decoder: N_SLV or TO_CYCLES out of range");
    end

    mmd_state_t       r_state;
    mmd_state_t       w_stateNext;
    logic [N_SLV-1:0] w_hit;
    logic [N_SLV-1:0] w_hitOnehot;
    logic [IDX_W-1:0] w_hitIdx;
    logic             w_anyHit;
    logic             w_accept;
    logic             w_ackSel;
    logic             w_timeout;

    logic [IDX_W-1:0] r_idx;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_slvWe;
    logic [N_SLV-1:0] r_sel;
    logic [DW-1:0]    r_rdata;
    logic             r_ready;
    logic             r_err;

    for (genvar g = 0; g < N_SLV; g++) begin : g_region
        mmd_region_match #(.AW(AW)) u_match (
            .i_base (BASE[g*AW +: AW]),
            .i_limit(LIMIT[g*AW +: AW]),
            .i_addr (cpu_addr),
            .o_hit  (w_hit[g])
        );
    end

    // Overlapping windows resolve to the lowest index.
    always_comb begin
        w_hitIdx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hitIdx = IDX_W'(i);
            end
        end
    end

    assign w_hitOnehot = w_hit & (~w_hit + N_SLV'(1));
    assign w_anyHit    = |w_hit;
    assign w_accept    = (r_state == IDLE) && cpu_req && w_anyHit;
    assign w_ackSel    = slv_ack[r_idx];

`ifdef MMD_TIMEOUT_EN
    logic [7:0] r_toCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toCnt <= 8'd0;
        end else if (r_state != ACCESS) begin
            r_toCnt <= 8'd0;
        end else begin
            r_toCnt <= r_toCnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ACCESS) && (r_toCnt == 8'(TO_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // An ack arriving in the same cycle as the timeout still completes normally.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    w_stateNext = w_anyHit ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                if (w_ackSel) begin
                    w_stateNext = RESP;
                end else if (w_timeout) begin
                    w_stateNext = ERR;
                end
            end
            RESP:    w_stateNext = IDLE;
            ERR:     w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= (w_stateNext == RESP) || (w_stateNext == ERR);
            r_err   <= (w_stateNext == ERR);
            if ((r_state == ACCESS) && w_ackSel && !r_slvWe) begin
                r_rdata <= slv_rdata[r_idx*DW +: DW];
            end else begin
                r_rdata <= '0;
            end
        end
    end

    // Select and write strobe only live while in ACCESS; address/data stay latched afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_slvWe <= 1'b0;
            r_sel   <= '0;
        end else begin
            if (w_accept) begin
                r_idx   <= w_hitIdx;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_slvWe <= cpu_we;
                r_sel   <= w_hitOnehot;
            end else if (w_stateNext != ACCESS) begin
                r_slvWe <= 1'b0;
                r_sel   <= '0;
            end
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign cpu_err   = r_err;
    assign slv_addr  = r_addr;
    assign slv_wdata = r_wdata;
    assign slv_we    = r_slvWe;
    assign slv_sel   = r_sel;

endmodule
